// File: rtl/uart_pkg.sv
// Shared timing helpers and arbiter state encoding for the UART transmit path.
// Frame length = start + 8 data + parity/stop slots (11 bit periods) plus idle gap bits.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic int frame_cycles(input int clk_freq, input int uart_bps, input int gap_bits);
    return baud_cnt_max(clk_freq, uart_bps) * (11 + gap_bits);
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Frame pacing counter: start clears and arms it; done pulses (combinationally) when the
// counter reaches CYCLES-2, i.e. CYCLES-1 cycles after start. No backpressure.
module uart_frame_timer #(
  parameter int CYCLES = 120
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic start,
  output logic done
);

  localparam int CNT_W = $clog2(CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 2);

  logic [CNT_W-1:0] cnt;
  logic             active;

  assign done = active && (cnt == CNT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      cnt    <= cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between two byte requesters; grant visible one cycle
// after req is sampled in IDLE. Requests are held off (no ack) for the whole frame while busy.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000,
  parameter int GAP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       busy
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int FRAME_CYCLES = frame_cycles(CLK_FREQ, UART_BPS, GAP_BITS);

  if (FRAME_CYCLES < 4) begin : g_frame_check
    $error("uart_tx_arb: FRAME_CYCLES (%0d) must be at least 4", FRAME_CYCLES);
  end

  arb_state_t state_q, state_d;
  logic       last_grant, last_grant_d;
  logic       ack0_d, ack1_d, po_flag_d, busy_d;
  logic [7:0] po_data_d;
  logic       timer_start, timer_done;

  uart_frame_timer #(.CYCLES(FRAME_CYCLES)) u_frame_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (timer_start),
    .done      (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    po_flag_d    = 1'b0;
    busy_d       = busy;
    po_data_d    = po_data;
    timer_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time gets the line.
        if (req0 && (!req1 || last_grant)) begin
          po_data_d    = data0;
          ack0_d       = 1'b1;
          po_flag_d    = 1'b1;
          busy_d       = 1'b1;
          last_grant_d = 1'b0;
          state_d      = SEND;
        end else if (req1) begin
          po_data_d    = data1;
          ack1_d       = 1'b1;
          po_flag_d    = 1'b1;
          busy_d       = 1'b1;
          last_grant_d = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        timer_start = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (timer_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      po_flag    <= 1'b0;
      busy       <= 1'b0;
      po_data    <= 8'h00;
    end else begin
      state_q    <= state_d;
      last_grant <= last_grant_d;
      ack0       <= ack0_d;
      ack1       <= ack1_d;
      po_flag    <= po_flag_d;
      busy       <= busy_d;
      po_data    <= po_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb at CLK_FREQ=1000, UART_BPS=100, GAP_BITS=1 (frame = 120 cycles).
// Inputs are driven and outputs sampled on the falling edge.
module tb_uart_tx_arb;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, po_flag, busy;
  logic [7:0] po_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int flag_cnt = 0;
  int ack_cnt = 0;

  uart_tx_arb #(.UART_BPS(100), .CLK_FREQ(1000), .GAP_BITS(1)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req0      (req0),
    .data0     (data0),
    .ack0      (ack0),
    .req1      (req1),
    .data1     (data1),
    .ack1      (ack1),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (po_flag) flag_cnt <= flag_cnt + 1;
    if (ack0 || ack1) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  // Waits for an ack pulse; returns its cycle and which requester got it.
  task automatic wait_ack(input int limit, output int at, output logic which);
    at = -1;
    which = 1'b0;
    for (int i = 0; i < limit && at < 0; i++) begin
      @(negedge sys_clk);
      if (ack0 || ack1) begin
        at = cyc;
        which = ack1;
      end
    end
    if (at < 0) chk("ack_timeout", 0, 1);
  endtask

  initial begin
    int   t, t_prev, n, chg, nf;
    logic w;
    logic done;

    // Reset state
    do_reset();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_flag", po_flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", po_data, 8'h00);

    // Single request: one frame of exactly 120 busy cycles with data held
    data0 = 8'hA5;
    req0  = 1'b1;
    wait_ack(50, t, w);
    chk("t1_grant", w, 0);
    chk("t1_flag", po_flag, 1);
    chk("t1_busy", busy, 1);
    chk("t1_data", po_data, 8'hA5);
    chk("t1_ack1", ack1, 0);
    req0 = 1'b0;
    n = 1; chg = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge sys_clk);
      if (busy) begin
        n++;
        if (po_data != 8'hA5) chg++;
        if (po_flag) chg++;
      end else begin
        done = 1'b1;
      end
    end
    chk("t1_busy_len", n, 120);
    chk("t1_hold", chg, 0);
    chk("t1_data_after", po_data, 8'hA5);

    // Continuous dual requests alternate starting with requester 0
    do_reset();
    data0 = 8'h11;
    data1 = 8'h22;
    req0 = 1'b1;
    req1 = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(400, t, w);
      chk("t2_grant", w, k[0]);
      chk("t2_data", po_data, k[0] ? 8'h22 : 8'h11);
      if (k > 0) chk("t2_spacing", t - t_prev, 121);
      t_prev = t;
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Request arriving mid-frame waits until the frame ends
    do_reset();
    data0 = 8'h33;
    req0 = 1'b1;
    wait_ack(50, t_prev, w);
    chk("t3_grant0", w, 0);
    req0 = 1'b0;
    repeat (15) @(negedge sys_clk);
    data1 = 8'h44;
    req1 = 1'b1;
    @(negedge sys_clk);
    chk("t3_no_ack1", ack1, 0);
    chk("t3_data_held", po_data, 8'h33);
    wait_ack(300, t, w);
    chk("t3_grant1", w, 1);
    chk("t3_delay", t - t_prev, 121);
    chk("t3_data_new", po_data, 8'h44);
    req1 = 1'b0;

    // Asynchronous reset mid-frame, then tie resolves to requester 0
    do_reset();
    data0 = 8'h5A;
    req0 = 1'b1;
    wait_ack(50, t, w);
    req0 = 1'b0;
    repeat (55) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_data", po_data, 8'h00);
    chk("t4_flag", po_flag, 0);
    data0 = 8'h77;
    data1 = 8'h88;
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_ack(50, t, w);
    chk("t4_grant", w, 0);
    chk("t4_gdata", po_data, 8'h77);
    req0 = 1'b0;
    req1 = 1'b0;

    // One-cycle request during busy is dropped without any ack
    repeat (20) @(negedge sys_clk);
    req0 = 1'b1;
    @(negedge sys_clk);
    req0 = 1'b0;
    n = ack_cnt;
    repeat (150) @(negedge sys_clk);
    chk("t5_no_ack", ack_cnt - n, 0);
    chk("t5_busy_end", busy, 0);

    // Request held through its ack: one grant per frame window only
    data0 = 8'hC3;
    req0 = 1'b1;
    wait_ack(50, t, w);
    nf = 1;
    repeat (241) begin
      @(negedge sys_clk);
      if (po_flag) nf++;
    end
    req0 = 1'b0;
    chk("t6_flags", nf, 2);
    nf = 0;
    repeat (150) begin
      @(negedge sys_clk);
      if (po_flag) nf++;
    end
    chk("t6_no_extra", nf, 0);
    chk("flag_eq_ack", flag_cnt, ack_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
